datapath_mc: RTL and testbench
==============================

Name: datapath_mc

Overview:
Parametrised multicycle RISC-V datapath. It executes RV32I-style integer instructions over several cycles and uses one shared instruction/data memory port. It holds the non-architectural registers (OldPC, IR, Data, A, B, ALUOut), the register file, the immediate extender and the ALU. An external controller FSM drives every mux select and register enable. A MemReady handshake stalls all state updates while memory is busy.

Parameters:
XLEN, 32, datapath width in bits; must be 32 or 64.
RESET_PC, 32'h0000_0000, PC value loaded on reset; zero-extended to XLEN.
NREGS, 32, number of architectural registers; x0 is hard-wired to zero.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
PCWrite  in  1  load PC with Result
AdrSrc  in  1  memory address select: 0=PC, 1=Result
IRWrite  in  1  load IR with ReadData and OldPC with PC
RegWrite  in  1  write Result to register rd
ResultSrc  in  2  00=ALUOut, 01=Data, 10=ALUResult, 11=reserved (drives ALUOut)
ALUSrcA  in  2  00=PC, 01=OldPC, 10=A, 11=reserved (drives 0)
ALUSrcB  in  2  00=B, 01=ImmExt, 10=constant 4, 11=reserved (drives 0)
ImmSrc  in  3  000=I, 001=S, 010=B, 011=J, 100=U; others give 0
ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), others give 0
MemReady  in  1  memory response valid / accepts access; 0 stalls
ReadData  in  XLEN  memory read data
Adr  out  XLEN  memory address
WriteData  out  XLEN  store data; equals register B
Instr  out  32  IR contents, for the controller decode
Zero  out  1  ALUResult == 0 (combinational)

Behaviour:
- Reset: when reset=1 at the clock edge, state becomes PC=OldPC=RESET_PC, IR=0, Data=A=B=ALUOut=0. Outputs then read Adr=RESET_PC, Instr=0, WriteData=0. Register file contents are not reset, except x0, which always reads 0. Reset has priority over every enable, including MemReady.
- Stall qualifier: every enabled write below takes effect only when MemReady=1. When MemReady=0, all registers hold, including the free-running A, B, Data and ALUOut, and register-file writes are suppressed.
- PC: PC <= Result when PCWrite is set. Result is also the PCNext value.
- IR/OldPC: when IRWrite is set, IR <= ReadData[31:0] and OldPC <= PC in the same edge.
- Free-running registers: Data <= ReadData, A <= rf[rs1], B <= rf[rs2] and ALUOut <= ALUResult update every unstalled cycle.
- Register file:
  - asynchronous reads at rs1 = Instr[19:15] and rs2 = Instr[24:20];
  - synchronous write of Result to rd = Instr[11:7];
  - writes to x0 are ignored;
  - writes to indices >= NREGS are ignored and reads of them return 0;
  - a read and a write to the same register in one cycle return the old value; there is no bypass.
- Immediates: all sign-extended from Instr[31] to XLEN.
  - I: Instr[31:20]
  - S: {Instr[31:25], Instr[11:7]}
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}
  - J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}
  - U: {Instr[31:12], 12'b0}
- ALU:
  - add and sub wrap modulo 2^XLEN;
  - slt gives 1 or 0 zero-extended;
  - Zero is derived from the combinational ALUResult.
- Adr: combinational from AdrSrc. Adr must be stable while MemReady=0; that is the controller's responsibility, and the datapath guarantees it because all state holds.
- Latency:
  - a fetch with IRWrite=1 and MemReady=1 makes Instr valid in the next cycle;
  - A and B are valid one cycle after Instr changes;
  - ALUOut lags ALUResult by one cycle.

Test Plan:
- Reset with RESET_PC=0x100, holding PCWrite=1 and MemReady=1 during reset → PC=Adr=0x100, Instr=0, WriteData=0, ALUOut=0 after the edge.
- Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1, ReadData=0x00500093 → next cycle Instr=0x00500093, OldPC=0x100, PC=0x104.
- addi x1,x0,5: execute cycle ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add → ALUOut=5. Write-back with ResultSrc=00, RegWrite=1 → x1=5. Then fetch `add x2,x1,x1` → B=5 and ALUResult=10.
- Stall: during fetch, MemReady=0 for 3 cycles with PCWrite=1 and IRWrite=1 → PC, IR, OldPC, ALUOut and Adr are unchanged for all 3 cycles. On the first MemReady=1 edge, PC=+4 and IR loads.
- x0 and unsigned wrap:
  - RegWrite=1 with rd=0 and Result=0xDEAD → rs1=x0 still reads 0;
  - A=0xFFFFFFFF plus 4 → ALUResult=0x3 and Zero=0;
  - sub of equal operands → Zero=1.
- Branch target: IR=beq with imm=-8, OldPC=0x120, ALUSrcA=01, ALUSrcB=01, ImmSrc=010 → ALUResult=0x118. Repeat with XLEN=64 → sign-extended result 0x0000_0000_0000_0118.

Source files
------------

// File: rtl/datapath_mc_if.sv
// Controller/memory bundle for the multicycle datapath.
// Controller and memory sit on the master side; the datapath is the slave.
interface datapath_mc_if #(
  parameter int XLEN = 32
) ();
  logic            PCWrite;
  logic            AdrSrc;
  logic            IRWrite;
  logic            RegWrite;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [2:0]      ImmSrc;
  logic [2:0]      ALUControl;
  logic            MemReady;
  logic [XLEN-1:0] ReadData;
  logic [XLEN-1:0] Adr;
  logic [XLEN-1:0] WriteData;
  logic [31:0]     Instr;
  logic            Zero;

  modport master (
    output PCWrite, AdrSrc, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, ALUControl,
    output MemReady, ReadData,
    input  Adr, WriteData, Instr, Zero
  );

  modport slave (
    input  PCWrite, AdrSrc, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, ALUControl,
    input  MemReady, ReadData,
    output Adr, WriteData, Instr, Zero
  );
endinterface

// File: rtl/datapath_mc.sv
// Multicycle RV32I-style datapath with one shared memory port.
// All sequencing comes from an external controller via the bus.
module datapath_mc #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input logic          clk,
  input logic          reset,
  datapath_mc_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NR = 6'(NREGS);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] old_pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rf [NREGS];

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            rs1_ok;
  logic            rs2_ok;
  logic            rd_ok;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] result;
  logic            lt;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  // x0 and indices beyond NREGS read as zero and never take writes
  assign rs1_ok = (rs1 != 5'd0) && ({1'b0, rs1} < NR);
  assign rs2_ok = (rs2 != 5'd0) && ({1'b0, rs2} < NR);
  assign rd_ok  = (rd  != 5'd0) && ({1'b0, rd}  < NR);

  assign rd1 = rs1_ok ? rf[rs1[AW-1:0]] : '0;
  assign rd2 = rs2_ok ? rf[rs2[AW-1:0]] : '0;

  always_comb begin
    imm_ext = '0;
    unique case (bus.ImmSrc)
      3'b000: imm_ext = {{(XLEN-12){ir[31]}}, ir[31:20]};
      3'b001: imm_ext = {{(XLEN-12){ir[31]}},
                         ir[31:25], ir[11:7]};
      3'b010: imm_ext = {{(XLEN-12){ir[31]}}, ir[7],
                         ir[30:25], ir[11:8], 1'b0};
      3'b011: imm_ext = {{(XLEN-20){ir[31]}}, ir[19:12],
                         ir[20], ir[30:21], 1'b0};
      3'b100: imm_ext = {{(XLEN-32){ir[31]}},
                         ir[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    unique case (bus.ALUSrcA)
      2'b00:   src_a = pc;
      2'b01:   src_a = old_pc;
      2'b10:   src_a = a;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    unique case (bus.ALUSrcB)
      2'b00:   src_b = b;
      2'b01:   src_b = imm_ext;
      2'b10:   src_b = XLEN'(4);
      default: src_b = '0;
    endcase
  end

  assign lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_result = '0;
    unique case (bus.ALUControl)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, lt};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = alu_out;
    unique case (bus.ResultSrc)
      2'b00:   result = alu_out;
      2'b01:   result = data;
      2'b10:   result = alu_result;
      default: result = alu_out;
    endcase
  end

  assign bus.Adr       = bus.AdrSrc ? result : pc;
  assign bus.WriteData = b;
  assign bus.Instr     = ir;
  assign bus.Zero      = (alu_result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= XLEN'(RESET_PC);
      old_pc  <= XLEN'(RESET_PC);
      ir      <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else if (bus.MemReady) begin
      if (bus.PCWrite) pc <= result;
      if (bus.IRWrite) begin
        ir     <= bus.ReadData[31:0];
        old_pc <= pc;
      end
      data    <= bus.ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  end

  // no reset on the array; reads return the pre-write value
  always_ff @(posedge clk) begin
    if (!reset && bus.MemReady && bus.RegWrite && rd_ok)
      rf[rd[AW-1:0]] <= result;
  end
endmodule

// File: tb/tb_datapath_mc.sv
// Directed + random bench for datapath_mc against a reference model.
// Also checks a 64-bit, 16-register build on the key cases.
module tb_datapath_mc;
  logic clk = 1'b0;
  logic reset;
  logic rst64;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  datapath_mc_if #(.XLEN(32)) bus ();
  datapath_mc_if #(.XLEN(64)) b64 ();

  datapath_mc #(
    .XLEN(32), .RESET_PC(32'h100), .NREGS(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  datapath_mc #(
    .XLEN(64), .RESET_PC(32'h120), .NREGS(16)
  ) dut64 (
    .clk(clk), .reset(rst64), .bus(b64)
  );

  // reference model state
  logic [31:0] m_pc, m_old, m_ir, m_data;
  logic [31:0] m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];
  logic [31:0] e_alu, e_result, e_adr;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h expected %h",
                tag, got, exp);
  endtask

  function automatic logic [31:0] m_imm(
    logic [31:0] ir, logic [2:0] src);
    longint v;
    v = 0;
    case (src)
      3'd0: begin
        v = longint'(ir[31:20]);
        if (ir[31]) v -= 4096;
      end
      3'd1: begin
        v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
        if (ir[31]) v -= 4096;
      end
      3'd2: begin
        v = longint'(ir[31]) * 4096
          + longint'(ir[7]) * 2048
          + longint'(ir[30:25]) * 32
          + longint'(ir[11:8]) * 2;
        if (ir[31]) v -= 8192;
      end
      3'd3: begin
        v = longint'(ir[31]) * (64'd1 << 20)
          + longint'(ir[19:12]) * 4096
          + longint'(ir[20]) * 2048
          + longint'(ir[30:21]) * 2;
        if (ir[31]) v -= (64'd1 << 21);
      end
      3'd4: v = longint'(ir[31:12]) * 4096;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_alu(
    logic [31:0] x, logic [31:0] y, logic [2:0] op);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_eval();
    logic [31:0] sa, sb;
    case (bus.ALUSrcA)
      2'd0: sa = m_pc;
      2'd1: sa = m_old;
      2'd2: sa = m_a;
      default: sa = 0;
    endcase
    case (bus.ALUSrcB)
      2'd0: sb = m_b;
      2'd1: sb = m_imm(m_ir, bus.ImmSrc);
      2'd2: sb = 4;
      default: sb = 0;
    endcase
    e_alu = m_alu(sa, sb, bus.ALUControl);
    case (bus.ResultSrc)
      2'd1: e_result = m_data;
      2'd2: e_result = e_alu;
      default: e_result = m_aluout;
    endcase
    e_adr = bus.AdrSrc ? e_result : m_pc;
  endtask

  task automatic m_reset();
    m_pc = 32'h100; m_old = 32'h100; m_ir = 0;
    m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
  endtask

  task automatic m_step();
    logic [31:0] na, nb, pc0;
    if (reset) begin
      m_reset();
    end else if (bus.MemReady) begin
      na = m_rf[m_ir[19:15]];
      nb = m_rf[m_ir[24:20]];
      pc0 = m_pc;
      if (bus.RegWrite && m_ir[11:7] != 0)
        m_rf[m_ir[11:7]] = e_result;
      if (bus.PCWrite) m_pc = e_result;
      if (bus.IRWrite) begin
        m_ir = bus.ReadData;
        m_old = pc0;
      end
      m_data = bus.ReadData;
      m_a = na;
      m_b = nb;
      m_aluout = e_alu;
    end
  endtask

  task automatic tick();
    #1;
    m_eval();
    check("m_adr", bus.Adr, e_adr);
    check("m_wdata", bus.WriteData, m_b);
    check("m_instr", bus.Instr, m_ir);
    check("m_zero", bus.Zero, e_alu == 0);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic ctl(logic pcw, logic adrs, logic irw,
                     logic rw, logic [1:0] rs,
                     logic [1:0] sa, logic [1:0] sb,
                     logic [2:0] is, logic [2:0] ac);
    bus.PCWrite = pcw; bus.AdrSrc = adrs;
    bus.IRWrite = irw; bus.RegWrite = rw;
    bus.ResultSrc = rs; bus.ALUSrcA = sa;
    bus.ALUSrcB = sb; bus.ImmSrc = is;
    bus.ALUControl = ac;
  endtask

  task automatic ctl64(logic pcw, logic adrs, logic irw,
                       logic rw, logic [1:0] rs,
                       logic [1:0] sa, logic [1:0] sb,
                       logic [2:0] is, logic [2:0] ac);
    b64.PCWrite = pcw; b64.AdrSrc = adrs;
    b64.IRWrite = irw; b64.RegWrite = rw;
    b64.ResultSrc = rs; b64.ALUSrcA = sa;
    b64.ALUSrcB = sb; b64.ImmSrc = is;
    b64.ALUControl = ac;
  endtask

  task automatic fetch(logic [31:0] instr);
    ctl(1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 0);
    bus.ReadData = instr;
    tick();
  endtask

  task automatic idle();
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic edge64();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    ctl(1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 0);
    bus.MemReady = 1; bus.ReadData = 0;
    ctl64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b64.MemReady = 1; b64.ReadData = 0;
    rst64 = 1;
    reset = 1;
    @(posedge clk);
    m_reset();
    #1;
    reset = 0;

    // reset state
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_adr", bus.Adr, 32'h100);
    check("rst_instr", bus.Instr, 0);
    check("rst_wdata", bus.WriteData, 0);
    bus.AdrSrc = 1;
    #1;
    check("rst_aluout", bus.Adr, 0);

    // give every register a known value
    for (int r = 1; r < 32; r++) begin
      ctl(0, 0, 1, 0, 0, 0, 0, 0, 0);
      bus.ReadData = 32'(r) << 7;
      tick();
      ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.ReadData = $urandom;
      tick();
      ctl(0, 0, 0, 1, 2'b01, 0, 0, 0, 0);
      tick();
    end

    // fetch addi x1,x0,5
    fetch(32'h00500093);
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("fetch_instr", bus.Instr, 32'h00500093);
    check("fetch_pc", bus.Adr, 32'h104);
    ctl(0, 1, 0, 0, 2'b10, 2'b01, 2'b11, 0, 0);
    #1;
    check("fetch_oldpc", bus.Adr, 32'h100);
    idle();
    ctl(0, 1, 0, 0, 2'b10, 2'b10, 2'b01, 0, 0);
    #1;
    check("addi_alu", bus.Adr, 5);
    tick();
    ctl(0, 1, 0, 1, 2'b00, 2'b10, 2'b01, 0, 0);
    #1;
    check("addi_aluout", bus.Adr, 5);
    tick();

    // add x2,x1,x1
    fetch(32'h00108133);
    idle();
    check("add_b", bus.WriteData, 5);
    ctl(0, 1, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0);
    #1;
    check("add_alu", bus.Adr, 10);
    check("add_zero", bus.Zero, 0);
    tick();

    // stall during fetch
    ctl(1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 0);
    bus.ReadData = 32'h12345678;
    bus.MemReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", bus.Instr, 32'h00108133);
      check("stall_pc", bus.Adr, 32'h108);
    end
    bus.MemReady = 1;
    tick();
    check("unstall_pc", bus.Adr, 32'h10C);
    check("unstall_instr", bus.Instr, 32'h12345678);

    // write to x0 is dropped
    fetch(32'h00000013);
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ReadData = 32'hDEAD;
    tick();
    ctl(0, 1, 0, 1, 2'b01, 0, 0, 0, 0);
    #1;
    check("x0_result", bus.Adr, 32'hDEAD);
    tick();
    idle();
    ctl(0, 1, 0, 0, 2'b10, 2'b10, 2'b11, 0, 0);
    #1;
    check("x0_read", bus.Adr, 0);
    check("x0_zero", bus.Zero, 1);

    // 0xFFFFFFFF + 4 wraps
    fetch(32'h00418193);
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ReadData = 32'hFFFFFFFF;
    tick();
    ctl(0, 1, 0, 1, 2'b01, 0, 0, 0, 0);
    tick();
    idle();
    ctl(0, 1, 0, 0, 2'b10, 2'b10, 2'b10, 0, 0);
    #1;
    check("wrap_alu", bus.Adr, 3);
    check("wrap_zero", bus.Zero, 0);

    // sub of equal operands
    fetch(32'h003182B3);
    idle();
    ctl(0, 1, 0, 0, 2'b10, 2'b10, 2'b00, 0, 1);
    #1;
    check("sub_alu", bus.Adr, 0);
    check("sub_zero", bus.Zero, 1);
    check("sub_b", bus.WriteData, 32'hFFFFFFFF);

    // branch target from OldPC=0x120
    ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ReadData = 32'h120;
    tick();
    ctl(1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    tick();
    fetch(32'hFE000CE3);
    ctl(0, 1, 0, 0, 2'b10, 2'b01, 2'b01, 3'b010, 0);
    #1;
    check("beq_target", bus.Adr, 32'h118);
    tick();

    // random controls against the model
    for (int i = 0; i < 400; i++) begin
      ctl($urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom,
          $urandom, $urandom);
      bus.MemReady = ($urandom_range(3) != 0);
      bus.ReadData = $urandom;
      reset = ($urandom_range(63) == 0);
      tick();
    end
    reset = 0;

    // 64-bit build, 16 registers
    edge64();
    rst64 = 0;
    #1;
    check("r64_pc", b64.Adr, 64'h120);
    ctl64(1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 0);
    b64.ReadData = 64'hFE000CE3;
    edge64();
    ctl64(0, 1, 0, 0, 2'b10, 2'b01, 2'b01, 3'b010, 0);
    #1;
    check("r64_beq", b64.Adr, 64'h118);
    ctl64(0, 1, 0, 0, 2'b10, 2'b11, 2'b01, 3'b100, 0);
    #1;
    check("r64_uimm", b64.Adr, 64'hFFFF_FFFF_FE00_0000);
    ctl64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("r64_pc4", b64.Adr, 64'h124);

    // x20 is beyond NREGS=16
    ctl64(1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 0);
    b64.ReadData = 64'h000A0A13;
    edge64();
    ctl64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b64.ReadData = 64'h55;
    edge64();
    ctl64(0, 1, 0, 1, 2'b01, 0, 0, 0, 0);
    #1;
    check("r64_wres", b64.Adr, 64'h55);
    edge64();
    ctl64(0, 0, 0, 0, 0, 0, 0, 0, 0);
    edge64();
    ctl64(0, 1, 0, 0, 2'b10, 2'b10, 2'b11, 0, 0);
    #1;
    check("r64_oob", b64.Adr, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
